// File: rtl/aes_iter_encrypt.sv
// Iterative AES-128 encryption engine: UNROLL chained rounds per clock,
// with a valid/ready handshake on both sides and a sideband tag per block.
module aes_iter_encrypt #(
    parameter int UNROLL = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     plain_text,
    input  logic [127:0]     cipher_key,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     cipher_text,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes_iter_encrypt: UNROLL must be 1, 2, 5 or 10");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("aes_iter_encrypt: TAG_W must be at least 1");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, y;
        sq = a;
        y  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            y  = gmul(y, sq);
        end
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    // Byte i sits at bits [127-8i -: 8]; byte index is 4*column + row
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        if (r == 4'd9)  return 8'h1b;
        if (r == 4'd10) return 8'h36;
        return 8'h01 << (r - 4'd1);
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon(r), 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [1:0]       fsm_q, fsm_d;
    logic [127:0]     state_q, state_d, key_q, key_d, ct_q, ct_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [TAG_W-1:0] tag_q, tag_d, otag_q, otag_d;
    logic [127:0]     st_n, key_n, sr;
    logic [3:0]       rnd_s;
    logic             accept;

    assign in_ready    = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready);
    assign out_valid   = (fsm_q == DONE);
    assign busy        = (fsm_q == BUSY);
    assign cipher_text = ct_q;
    assign out_tag     = otag_q;
    assign accept      = in_valid & in_ready;

    // UNROLL rounds chained combinationally; the last AES round skips MixColumns
    always_comb begin
        st_n  = state_q;
        key_n = key_q;
        rnd_s = rnd_q;
        sr    = '0;
        for (int s = 0; s < UNROLL; s++) begin
            rnd_s = rnd_q + 4'(s);
            key_n = next_key(key_n, rnd_s);
            sr    = sub_shift(st_n);
            st_n  = ((rnd_s == 4'd10) ? sr : mix(sr)) ^ key_n;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        tag_d   = tag_q;
        ct_d    = ct_q;
        otag_d  = otag_q;
        case (fsm_q)
            BUSY: begin
                state_d = st_n;
                key_d   = key_n;
                rnd_d   = rnd_q + 4'(UNROLL);
                if (rnd_q + 4'(UNROLL - 1) == 4'd10) begin
                    ct_d   = st_n;
                    otag_d = tag_q;
                    fsm_d  = DONE;
                end
            end
            DONE:    if (out_ready) fsm_d = IDLE;
            default: ;
        endcase
        // A same-edge accept in DONE overrides the return to IDLE
        if (accept) begin
            state_d = plain_text ^ cipher_key;
            key_d   = cipher_key;
            rnd_d   = 4'd1;
            tag_d   = in_tag;
            fsm_d   = BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            tag_q   <= '0;
            ct_q    <= '0;
            otag_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            tag_q   <= tag_d;
            ct_q    <= ct_d;
            otag_q  <= otag_d;
        end
    end
endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Bench for aes_iter_encrypt: four instances (UNROLL 1/2/5/10) checked against
// known-answer vectors and a table-driven AES-128 reference model.
module tb_aes_iter_encrypt;
    localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [7:0]   RC [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    localparam int           NCYC [4] = '{10, 5, 2, 1};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   iv = '0, ord = '0, ir, ov, bz;
    logic [127:0] pt = '0, key = '0;
    logic [3:0]   tg = '0;
    logic [127:0] ct [4];
    logic [3:0]   otg [4];
    logic [7:0]   sb [256];
    int           n_asrt = 0, n_fail = 0;

    always #5 clk = ~clk;

    aes_iter_encrypt #(.UNROLL(1),  .TAG_W(4)) u1  (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .plain_text(pt), .cipher_key(key), .in_tag(tg), .out_valid(ov[0]), .out_ready(ord[0]),
        .cipher_text(ct[0]), .out_tag(otg[0]), .busy(bz[0]));
    aes_iter_encrypt #(.UNROLL(2),  .TAG_W(4)) u2  (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .plain_text(pt), .cipher_key(key), .in_tag(tg), .out_valid(ov[1]), .out_ready(ord[1]),
        .cipher_text(ct[1]), .out_tag(otg[1]), .busy(bz[1]));
    aes_iter_encrypt #(.UNROLL(5),  .TAG_W(4)) u5  (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .plain_text(pt), .cipher_key(key), .in_tag(tg), .out_valid(ov[2]), .out_ready(ord[2]),
        .cipher_text(ct[2]), .out_tag(otg[2]), .busy(bz[2]));
    aes_iter_encrypt #(.UNROLL(10), .TAG_W(4)) u10 (.clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .plain_text(pt), .cipher_key(key), .in_tag(tg), .out_valid(ov[3]), .out_ready(ord[3]),
        .cipher_text(ct[3]), .out_tag(otg[3]), .busy(bz[3]));

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [7:0] m2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Textbook FIPS-197 cipher: full key expansion up front, then 10 rounds on a byte array
    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   s [16], u [16];
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0)
                t = {sb[t[23:16]] ^ RC[i/4-1], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]};
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) u[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = u[4*((c+r)%4)+r];
            if (rd < 10) begin
                for (int i = 0; i < 16; i++) u[i] = s[i];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        s[4*c+r] = m2(u[4*c+r]) ^ m2(u[4*c+(r+1)%4]) ^ u[4*c+(r+1)%4]
                                 ^ u[4*c+(r+2)%4] ^ u[4*c+(r+3)%4];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd+i/4][31-8*(i%4) -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accept one block on instance k, optionally scramble inputs while it runs, leave result held
    task automatic run_block(input int k, input logic [127:0] k_, input logic [127:0] p_,
                             input logic [3:0] t_, input bit toggle, output int lat);
        int w;
        key = k_; pt = p_; tg = t_; iv[k] = 1'b1;
        w = 0;
        while (!ir[k] && w < 50) begin step(); w++; end
        chk("in_ready_before_accept", 128'(ir[k]), 128'(1));
        step();
        iv[k] = 1'b0;
        lat = 0;
        while (!ov[k] && lat < 30) begin
            if (toggle) begin key = rnd128(); pt = rnd128(); tg = 4'($urandom); end
            step();
            lat++;
        end
    endtask

    task automatic consume(input int k);
        ord[k] = 1'b1;
        step();
        ord[k] = 1'b0;
    endtask

    logic [127:0] exp_ct, cur_pt, held_ct;
    logic [127:0] q_ct [$];
    logic [3:0]   q_tg [$];
    int           lat, lats [4], nres, last, blk;
    bit           acc, cons;

    initial begin
        build_sbox();
        // reset state on every instance
        step(); step();
        for (int k = 0; k < 4; k++) begin
            chk("rst_in_ready", 128'(ir[k]), 128'(1));
            chk("rst_out_valid", 128'(ov[k]), 128'(0));
            chk("rst_busy", 128'(bz[k]), 128'(0));
            chk("rst_cipher", ct[k], 128'(0));
            chk("rst_tag", 128'(otg[k]), 128'(0));
        end
        rst = 1'b0;

        // App. B on all four, with latency
        key = BK; pt = BP; tg = 4'd5; iv = 4'hF;
        step();
        iv = 4'h0;
        for (int k = 0; k < 4; k++) lats[k] = -1;
        for (int c = 1; c <= 14; c++) begin
            step();
            for (int k = 0; k < 4; k++) if (ov[k] && lats[k] < 0) lats[k] = c;
        end
        for (int k = 0; k < 4; k++) begin
            chk("appB_latency", 128'(lats[k]), 128'(NCYC[k]));
            chk("appB_cipher", ct[k], BC);
            chk("appB_tag", 128'(otg[k]), 128'(5));
        end
        ord = 4'hF; step(); ord = 4'h0;

        // App. C.1 known answer on UNROLL 10 and 2
        run_block(3, C1K, C1P, 4'd3, 1'b0, lat);
        chk("appC_cipher_u10", ct[3], C1C);
        consume(3);
        run_block(1, C1K, C1P, 4'd3, 1'b0, lat);
        chk("appC_cipher_u2", ct[1], C1C);
        consume(1);

        // streaming with out_ready tied high, UNROLL 1 and 10
        foreach (NCYC[k]) begin
            if (k == 0 || k == 3) begin
                ord[k] = 1'b1; blk = 0; nres = 0; last = -1;
                q_ct.delete(); q_tg.delete();
                cur_pt = rnd128();
                for (int cyc = 0; cyc < 300 && nres < 8; cyc++) begin
                    if (blk < 8) begin iv[k] = 1'b1; key = C1K; pt = cur_pt; tg = 4'(blk); end
                    else iv[k] = 1'b0;
                    acc  = iv[k] & ir[k];
                    cons = ov[k] & ord[k];
                    if (cons && q_ct.size() > 0) begin
                        chk("stream_cipher", ct[k], q_ct.pop_front());
                        chk("stream_tag", 128'(otg[k]), 128'(q_tg.pop_front()));
                        if (nres > 0) chk("stream_period", 128'(cyc - last), 128'(NCYC[k] + 1));
                        last = cyc;
                        nres++;
                    end
                    step();
                    if (acc) begin
                        q_ct.push_back(aes_ref(C1K, cur_pt));
                        q_tg.push_back(4'(blk));
                        blk++;
                        cur_pt = rnd128();
                    end
                end
                chk("stream_count", 128'(nres), 128'(8));
                iv[k] = 1'b0; ord[k] = 1'b0;
            end
        end

        // back-pressure on UNROLL 1
        run_block(0, BK, BP, 4'd5, 1'b0, lat);
        chk("bp_first_valid", 128'(ov[0]), 128'(1));
        held_ct = ct[0];
        for (int c = 0; c < 20; c++) begin
            iv[0] = 1'b1; key = rnd128(); pt = rnd128(); tg = 4'($urandom);
            step();
            chk("bp_cipher", ct[0], BC);
            chk("bp_tag", 128'(otg[0]), 128'(5));
            chk("bp_valid", 128'(ov[0]), 128'(1));
            chk("bp_in_ready", 128'(ir[0]), 128'(0));
        end
        chk("bp_cipher_stable", ct[0], held_ct);
        key = C1K; pt = C1P; tg = 4'd9; iv[0] = 1'b1; ord[0] = 1'b1;
        #1;
        chk("bp_release_ready", 128'(ir[0]), 128'(1));
        step();
        iv[0] = 1'b0; ord[0] = 1'b0;
        chk("bp_reaccept_busy", 128'(bz[0]), 128'(1));
        chk("bp_reaccept_valid", 128'(ov[0]), 128'(0));
        lat = 0;
        while (!ov[0] && lat < 30) begin step(); lat++; end
        chk("bp_second_latency", 128'(lat), 128'(10));
        chk("bp_second_cipher", ct[0], C1C);
        chk("bp_second_tag", 128'(otg[0]), 128'(9));
        consume(0);

        // reset in the middle of BUSY
        key = BK; pt = BP; tg = 4'd5; iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_in_ready", 128'(ir[0]), 128'(1));
        chk("midrst_out_valid", 128'(ov[0]), 128'(0));
        chk("midrst_busy", 128'(bz[0]), 128'(0));
        chk("midrst_cipher", ct[0], 128'(0));
        chk("midrst_tag", 128'(otg[0]), 128'(0));
        run_block(0, BK, BP, 4'd5, 1'b0, lat);
        chk("midrst_appB_cipher", ct[0], BC);
        consume(0);

        // inputs scrambled every BUSY cycle must not disturb the block in flight
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                logic [127:0] kk, pp;
                logic [3:0]   tt;
                kk = rnd128(); pp = rnd128(); tt = 4'($urandom);
                exp_ct = aes_ref(kk, pp);
                run_block(k, kk, pp, tt, 1'b1, lat);
                chk("holdoff_latency", 128'(lat), 128'(NCYC[k]));
                chk("holdoff_cipher", ct[k], exp_ct);
                chk("holdoff_tag", 128'(otg[k]), 128'(tt));
                consume(k);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
